scan_shift_harness: RTL and testbench

Parametrised serial-scan harness for primitive minitests.
- Shifts a DIN_N-bit stimulus word in through one pin and commits it in parallel to the primitive under test on a strobe.
- Captures the primitive's DOUT_N-bit response after a programmable settle delay, then shifts it out through one pin.
- Keeps a top-level pin count of four regardless of primitive width. Adds reset, settle delay, busy flag and load/capture counters.

---
 rtl/scan_shift_harness.sv | 113 +++++++++++
 tb/tb_scan_shift_harness.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_shift_harness.sv
// Serial scan harness: shifts a stimulus word in on di_i, commits it to din_o on
// stb_i, captures dout_i after CAPTURE_DELAY edges and shifts it out on do_o.
// Ports: clk_i, rst_i (async, active-high), di_i, stb_i, dout_i -> do_o, din_o,
// busy_o (capture pending), load_cnt_o (bits since commit), cap_cnt_o (captures).
module scan_shift_harness #(
  parameter int DIN_N = 8,
  parameter int DOUT_N = 8,
  parameter int CAPTURE_DELAY = 0,
  parameter logic [DIN_N-1:0] DIN_RESET = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       di_i,
  input  logic                       stb_i,
  output logic                       do_o,
  output logic [DIN_N-1:0]           din_o,
  input  logic [DOUT_N-1:0]          dout_i,
  output logic                       busy_o,
  output logic [$clog2(DIN_N+1)-1:0] load_cnt_o,
  output logic [7:0]                 cap_cnt_o
);

  localparam int LW = $clog2(DIN_N + 1);
  localparam logic [LW-1:0] LD_MAX = LW'(DIN_N);
  localparam logic [3:0] DLY = 4'(CAPTURE_DELAY);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q;
  logic [3:0]        dly_q;
  logic [DIN_N-1:0]  din_shr_q;
  logic [DIN_N-1:0]  din_shr_d;
  logic [DOUT_N-1:0] dout_shr_q;
  logic [DOUT_N-1:0] dout_shr_d;
  logic [DOUT_N-1:0] dout_shift;
  logic [DIN_N-1:0]  din_q;
  logic [LW-1:0]     ld_q;
  logic [7:0]        cap_q;
  logic              din_msb;
  logic              accept;
  logic              capture;

  assign din_msb = din_shr_q[DIN_N-1];

  generate
    if (DIN_N == 1) begin : g_din1
      assign din_shr_d = di_i;
    end else begin : g_dinn
      assign din_shr_d = {din_shr_q[DIN_N-2:0], di_i};
    end
    if (DOUT_N == 1) begin : g_dout1
      assign dout_shift = din_msb;
    end else begin : g_doutn
      assign dout_shift = {dout_shr_q[DOUT_N-2:0], din_msb};
    end
  endgenerate

  // Only IDLE accepts a strobe; with zero delay the commit edge also captures.
  assign accept  = (state_q == S_IDLE) && stb_i;
  assign capture = (CAPTURE_DELAY == 0) ? accept :
                   ((state_q == S_WAIT) && (dly_q == 4'd1));

  assign dout_shr_d = capture ? dout_i : dout_shift;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      dly_q      <= 4'd0;
      din_shr_q  <= '0;
      dout_shr_q <= '0;
      din_q      <= DIN_RESET;
      ld_q       <= '0;
      cap_q      <= 8'd0;
    end else begin
      din_shr_q  <= din_shr_d;
      dout_shr_q <= dout_shr_d;
      if (accept) begin
        din_q <= din_shr_q;
        ld_q  <= '0;
      end else if (ld_q != LD_MAX) begin
        ld_q <= ld_q + LW'(1);
      end
      if (capture) begin
        cap_q <= cap_q + 8'd1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept && (CAPTURE_DELAY != 0)) begin
            state_q <= S_WAIT;
            dly_q   <= DLY;
          end
        end
        S_WAIT: begin
          dly_q <= dly_q - 4'd1;
          if (dly_q == 4'd1) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign do_o       = dout_shr_q[DOUT_N-1];
  assign din_o      = din_q;
  assign busy_o     = (state_q == S_WAIT);
  assign load_cnt_o = ld_q;
  assign cap_cnt_o  = cap_q;

endmodule

// File: tb/tb_scan_shift_harness.sv
// Bench for scan_shift_harness: three instances (delay 0, 3, 4) on shared inputs,
// checked against an edge-history model plus directed vectors.
module tb_scan_shift_harness;

  logic clk;
  logic rst;
  logic di;
  logic stb;
  logic [7:0] dout;

  wire [2:0]       do_w;
  wire [2:0]       busy_w;
  wire [2:0][7:0]  din_w;
  wire [2:0][3:0]  ld_w;
  wire [2:0][7:0]  cc_w;

  int checks = 0;
  int errors = 0;

  scan_shift_harness #(.DIN_N(8), .DOUT_N(8), .CAPTURE_DELAY(0),
                       .DIN_RESET(8'h00)) u0 (
    .clk_i(clk), .rst_i(rst), .di_i(di), .stb_i(stb),
    .do_o(do_w[0]), .din_o(din_w[0]), .dout_i(dout),
    .busy_o(busy_w[0]), .load_cnt_o(ld_w[0]), .cap_cnt_o(cc_w[0]));

  scan_shift_harness #(.DIN_N(8), .DOUT_N(8), .CAPTURE_DELAY(3),
                       .DIN_RESET(8'h5A)) u3 (
    .clk_i(clk), .rst_i(rst), .di_i(di), .stb_i(stb),
    .do_o(do_w[1]), .din_o(din_w[1]), .dout_i(dout),
    .busy_o(busy_w[1]), .load_cnt_o(ld_w[1]), .cap_cnt_o(cc_w[1]));

  scan_shift_harness #(.DIN_N(8), .DOUT_N(8), .CAPTURE_DELAY(4),
                       .DIN_RESET(8'hC3)) u4 (
    .clk_i(clk), .rst_i(rst), .di_i(di), .stb_i(stb),
    .do_o(do_w[2]), .din_o(din_w[2]), .dout_i(dout),
    .busy_o(busy_w[2]), .load_cnt_o(ld_w[2]), .cap_cnt_o(cc_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Reference model: everything derived from the di history since reset
  // and the edge indices of commits and captures.
  int dly_a [3];
  logic [7:0] drst [3];
  bit di_h [4096];
  int n;
  int pend [3];
  int la [3];
  int lc [3];
  int cap [3];
  logic [7:0] lv [3];
  logic [7:0] din_e [3];

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      pend[i]  = -1;
      la[i]    = -1;
      lc[i]    = -100;
      cap[i]   = 0;
      lv[i]    = 8'h00;
      din_e[i] = drst[i];
    end
  endtask

  task automatic model_step();
    logic [7:0] pre;
    pre = 8'h00;
    for (int j = 0; j < 8; j++)
      if (n - 1 - j >= 0) pre[j] = di_h[n-1-j];
    for (int i = 0; i < 3; i++) begin
      if (pend[i] < 0) begin
        if (stb) begin
          din_e[i] = pre;
          la[i] = n;
          if (dly_a[i] == 0) begin
            cap[i] = (cap[i] + 1) % 256;
            lc[i] = n;
            lv[i] = dout;
          end else begin
            pend[i] = n + dly_a[i];
          end
        end
      end else if (n == pend[i]) begin
        cap[i] = (cap[i] + 1) % 256;
        lc[i] = n;
        lv[i] = dout;
        pend[i] = -1;
      end
    end
    if (n < 4096) di_h[n] = di;
    n++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all();
    int t;
    int e_ld;
    int e_do;
    int k;
    t = n - 1;
    for (int i = 0; i < 3; i++) begin
      e_ld = (t - la[i] > 8) ? 8 : (t - la[i]);
      if (lc[i] >= 0 && t - lc[i] < 8) begin
        e_do = lv[i][7-(t-lc[i])];
      end else begin
        k = t - 15;
        e_do = (k >= 0) ? int'(di_h[k]) : 0;
      end
      chk($sformatf("m%0d.do", i), do_w[i], e_do);
      chk($sformatf("m%0d.din", i), din_w[i], din_e[i]);
      chk($sformatf("m%0d.busy", i), busy_w[i], (pend[i] >= 0) ? 1 : 0);
      chk($sformatf("m%0d.load", i), ld_w[i], e_ld);
      chk($sformatf("m%0d.cap", i), cc_w[i], cap[i]);
    end
  endtask

  task automatic step(input logic d, input logic s, input logic [7:0] v);
    di = d;
    stb = s;
    dout = v;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
  endtask

  typedef struct {
    logic       di;
    logic       stb;
    logic [7:0] dout;
    logic       e_do;
    logic [7:0] e_din;
    logic [7:0] e_cap;
    logic [3:0] e_ld;
  } vec_t;

  vec_t tbl [16];

  initial begin
    dly_a[0] = 0; dly_a[1] = 3; dly_a[2] = 4;
    drst[0] = 8'h00; drst[1] = 8'h5A; drst[2] = 8'hC3;
    tbl[0]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd1};
    tbl[1]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd2};
    tbl[2]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd3};
    tbl[3]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd4};
    tbl[4]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd5};
    tbl[5]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd6};
    tbl[6]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd7};
    tbl[7]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 8'd0, 4'd8};
    tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'hA5, 8'd1, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'hA5, 8'd1, 4'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 8'd1, 4'd2};
    tbl[11] = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 8'd1, 4'd3};
    tbl[12] = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 8'd1, 4'd4};
    tbl[13] = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 8'd1, 4'd5};
    tbl[14] = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'hA5, 8'd1, 4'd6};
    tbl[15] = '{1'b0, 1'b0, 8'h3C, 1'b0, 8'hA5, 8'd1, 4'd7};

    rst = 1'b1; di = 1'b0; stb = 1'b0; dout = 8'h00;
    #1;
    model_reset();
    check_all();
    chk("rst0.din3", din_w[1], 8'h5A);
    chk("rst0.din4", din_w[2], 8'hC3);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].di, tbl[i].stb, tbl[i].dout);
      chk($sformatf("tbl%0d.do", i), do_w[0], tbl[i].e_do);
      chk($sformatf("tbl%0d.din", i), din_w[0], tbl[i].e_din);
      chk($sformatf("tbl%0d.cap", i), cc_w[0], tbl[i].e_cap);
      chk($sformatf("tbl%0d.load", i), ld_w[0], tbl[i].e_ld);
    end

    async_reset();
    chk("midrst.do", do_w[0], 0);
    chk("midrst.din", din_w[0], 8'h00);
    chk("midrst.cap", cc_w[0], 0);
    chk("midrst.din3", din_w[1], 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    step(1'b0, 1'b1, 8'h00);
    chk("d3.busy_a0", busy_w[1], 1);
    step(1'b0, 1'b0, 8'hFF);
    chk("d3.busy_a1", busy_w[1], 1);
    step(1'b0, 1'b0, 8'hFF);
    chk("d3.busy_a2", busy_w[1], 1);
    chk("d3.cap_a2", cc_w[1], 0);
    step(1'b0, 1'b0, 8'hFF);
    chk("d3.busy_a3", busy_w[1], 0);
    chk("d3.do_a3", do_w[1], 1);
    chk("d3.cap_a3", cc_w[1], 1);

    begin
      logic [7:0] pat;
      pat = 8'h96;
      for (int i = 7; i >= 0; i--) step(pat[i], 1'b0, 8'h00);
    end
    step(1'b1, 1'b1, 8'h00);
    chk("w3.din_b0", din_w[1], 8'h96);
    chk("w3.busy_b0", busy_w[1], 1);
    step(1'b0, 1'b1, 8'h00);
    chk("w3.din_b1", din_w[1], 8'h96);
    chk("w3.load_b1", ld_w[1], 1);
    step(1'b1, 1'b1, 8'h00);
    chk("w3.din_b2", din_w[1], 8'h96);
    chk("w3.load_b2", ld_w[1], 2);
    step(1'b0, 1'b0, 8'h00);
    chk("w3.cap_b3", cc_w[1], 2);
    chk("w3.busy_b3", busy_w[1], 0);
    step(1'b0, 1'b0, 8'h00);
    chk("w3.cap_b4", cc_w[1], 2);
    chk("w3.load_b4", ld_w[1], 4);

    async_reset();
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'hFF);
    async_reset();
    chk("d4.abort_cap", cc_w[2], 0);
    chk("d4.abort_busy", busy_w[2], 0);
    step(1'b0, 1'b0, 8'hFF);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hAA);
    chk("d4.busy_c3", busy_w[2], 1);
    chk("d4.cap_c3", cc_w[2], 0);
    step(1'b0, 1'b0, 8'hAA);
    chk("d4.cap_c4", cc_w[2], 1);
    chk("d4.busy_c4", busy_w[2], 0);
    chk("d4.do_c4", do_w[2], 1);

    async_reset();
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'b0, 8'($urandom));
    chk("sat.load0", ld_w[0], 8);
    chk("sat.load4", ld_w[2], 8);
    for (int i = 0; i < 255; i++) step(1'($urandom), 1'b1, 8'($urandom));
    chk("wrap.cap255", cc_w[0], 255);
    step(1'b0, 1'b1, 8'h00);
    chk("wrap.cap0", cc_w[0], 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        async_reset();
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
      end
      step(1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
